mips_mem_responder: RTL and testbench

Byte-wide memory responder that serves the far end of the multicycle MIPS core's memory bus (`adr`, `memread`, `memwrite`, `writedata` in, `memdata` out). On reset it enters a load phase: the core is held in reset while a byte-serial loader fills program memory through a valid/ready port. It then releases the core and answers its fetches, loads and stores. One store address is decoded as an output port so program results leave the chip.

---
 rtl/mips_mem_pkg.sv | 25 ++
 rtl/mips_mem_responder_bytemem.sv | 61 ++++++
 rtl/mips_mem_responder.sv | 149 ++++++++++++++
 tb/tb_mips_mem_responder.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// ============================================================================
// Module      : mips_mem_pkg
// Description : Shared types and default constants for the MIPS memory
//               responder (state encoding, RAM depth, output-port address).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mips_mem_pkg;

  // Responder phase: LOAD fills program memory, RUN serves the core
  typedef enum logic [0:0] {
    LOAD = 1'b0,
    RUN  = 1'b1
  } memstate_t;

  // Default RAM address bits (64 bytes)
  localparam int MEM_ADRBITS = 6;

  // Default full-width store address decoded as the output port
  localparam logic [7:0] MEM_OUT_ADR = 8'hFF;

endpackage : mips_mem_pkg

`default_nettype wire

// File: rtl/mips_mem_responder_bytemem.sv
// ============================================================================
// Module      : bytemem
// Description : Byte RAM with one asynchronous read port and one synchronous
//               write port. The write source is the loader during LOAD and
//               the core during RUN.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module bytemem #(
  parameter int WIDTH   = 8,
  parameter int ADRBITS = 6
) (
  input  logic               clk,
  input  logic               i_load_mode,
  input  logic               i_load_we,
  input  logic [ADRBITS-1:0] i_load_adr,
  input  logic [7:0]         i_load_data,
  input  logic               i_core_we,
  input  logic [ADRBITS-1:0] i_core_adr,
  input  logic [WIDTH-1:0]   i_core_wdata,
  input  logic [ADRBITS-1:0] i_rd_adr,
  output logic [WIDTH-1:0]   o_rd_data
);

  localparam int DEPTH = 2 ** ADRBITS;

  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_we;
  logic [ADRBITS-1:0] w_wadr;
  logic [WIDTH-1:0]   w_wdata;

  // Write-source mux: loader owns the port in LOAD, core owns it in RUN
  always_comb begin
    w_we    = 1'b0;
    w_wadr  = '0;
    w_wdata = '0;
    if (i_load_mode) begin
      w_we    = i_load_we;
      w_wadr  = i_load_adr;
      w_wdata = WIDTH'(i_load_data);
    end else begin
      w_we    = i_core_we;
      w_wadr  = i_core_adr;
      w_wdata = i_core_wdata;
    end
  end

  // Synchronous write; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_wadr] <= w_wdata;
    end
  end

  // Asynchronous read so the core can latch data in the same cycle
  assign o_rd_data = r_mem[i_rd_adr];

endmodule : bytemem

`default_nettype wire

// File: rtl/mips_mem_responder.sv
// ============================================================================
// Module      : mips_mem_responder
// Description : Memory responder for the multicycle MIPS core. Holds the core
//               in reset while a byte-serial loader fills RAM, then serves
//               core fetches/loads/stores. One store address is an output port.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mips_mem_responder
  import mips_mem_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               ADRBITS = MEM_ADRBITS,
  parameter logic [WIDTH-1:0] OUT_ADR = WIDTH'(MEM_OUT_ADR)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] adr,
  input  logic             memread,
  input  logic             memwrite,
  input  logic [WIDTH-1:0] writedata,
  output logic [WIDTH-1:0] memdata,
  output logic             cpu_reset,
  input  logic             load_valid,
  input  logic [7:0]       load_data,
  input  logic             load_last,
  output logic             load_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             running
);

  localparam logic [ADRBITS-1:0] c_PTR_MAX = {ADRBITS{1'b1}};

  memstate_t          r_state;
  memstate_t          w_next_state;
  logic [ADRBITS-1:0] r_ptr;
  logic [WIDTH-1:0]   r_out_data;
  logic               r_out_valid;

  logic               w_in_load;
  logic               w_load_fire;
  logic               w_load_done;
  logic               w_is_out;
  logic               w_core_ram_we;
  logic               w_out_we;
  logic [WIDTH-1:0]   w_rd_data;

  assign w_in_load     = (r_state == LOAD);
  assign w_load_fire   = w_in_load & load_valid;
  // Explicit last byte, or the byte that fills the final RAM location
  assign w_load_done   = w_load_fire & (load_last | (r_ptr == c_PTR_MAX));
  assign w_is_out      = (adr == OUT_ADR);
  assign w_core_ram_we = (r_state == RUN) & memwrite & ~w_is_out;
  assign w_out_we      = (r_state == RUN) & memwrite & w_is_out;

  // State register; reset always returns to LOAD
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= LOAD;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state: LOAD advances on the last accepted byte, RUN is sticky
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      LOAD:    if (w_load_done) w_next_state = RUN;
      RUN:     w_next_state = RUN;
      default: w_next_state = LOAD;
    endcase
  end

  // State-decoded outputs; cpu_reset follows state so the core is released
  // exactly on the first RUN cycle
  always_comb begin
    load_ready = 1'b0;
    cpu_reset  = 1'b0;
    running    = 1'b0;
    case (r_state)
      LOAD: begin
        load_ready = 1'b1;
        cpu_reset  = 1'b1;
      end
      RUN: begin
        running = 1'b1;
      end
      default: begin
        load_ready = 1'b0;
        cpu_reset  = 1'b1;
      end
    endcase
  end

  // Load pointer: advances per accepted byte, wraps naturally at the top
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (w_load_fire) begin
      r_ptr <= r_ptr + ADRBITS'(1);
    end
  end

  // Output port register with a one-cycle valid pulse per store
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= w_out_we;
      if (w_out_we) begin
        r_out_data <= writedata;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;

  bytemem #(
    .WIDTH   (WIDTH),
    .ADRBITS (ADRBITS)
  ) u_mem (
    .clk          (clk),
    .i_load_mode  (w_in_load),
    .i_load_we    (w_load_fire),
    .i_load_adr   (r_ptr),
    .i_load_data  (load_data),
    .i_core_we    (w_core_ram_we),
    .i_core_adr   (adr[ADRBITS-1:0]),
    .i_core_wdata (writedata),
    .i_rd_adr     (adr[ADRBITS-1:0]),
    .o_rd_data    (w_rd_data)
  );

  // Zero-latency read mux; output-port address reads back the last store
  always_comb begin
    memdata = '0;
    if ((r_state == RUN) && memread) begin
      memdata = w_is_out ? r_out_data : w_rd_data;
    end
  end

endmodule : mips_mem_responder

`default_nettype wire

// File: tb/tb_mips_mem_responder.sv
// ============================================================================
// Module      : tb_mips_mem_responder
// Description : Directed self-checking bench for mips_mem_responder.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mips_mem_responder;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] adr;
  logic       memread;
  logic       memwrite;
  logic [7:0] writedata;
  logic [7:0] memdata;
  logic       cpu_reset;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_last;
  logic       load_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       running;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mips_mem_responder #(
    .WIDTH   (8),
    .ADRBITS (6),
    .OUT_ADR (8'hFF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .adr        (adr),
    .memread    (memread),
    .memwrite   (memwrite),
    .writedata  (writedata),
    .memdata    (memdata),
    .cpu_reset  (cpu_reset),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_last  (load_last),
    .load_ready (load_ready),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .running    (running)
  );

  // Advance past the next rising edge; inputs change and outputs settle 1ns after
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    memread    = 1'b0;
    memwrite   = 1'b0;
    adr        = 8'h00;
    writedata  = 8'h00;
    load_valid = 1'b0;
    load_data  = 8'h00;
    load_last  = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  // Present one loader byte for one cycle; core must be held in reset meanwhile
  task automatic load_byte(input logic [7:0] d, input logic last);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    #1;
    n_tests++;
    if (cpu_reset !== 1'b1 || load_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_hold: cpu_reset=%b load_ready=%b required 1/1", cpu_reset, load_ready);
    end
    tick();
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  // Combinational read in RUN; value returned for caller's inline compare
  task automatic core_read(input logic [7:0] a, output logic [7:0] d);
    memread  = 1'b1;
    memwrite = 1'b0;
    adr      = a;
    #1;
    d = memdata;
    memread = 1'b0;
  endtask

  task automatic core_write(input logic [7:0] a, input logic [7:0] d);
    memwrite  = 1'b1;
    adr       = a;
    writedata = d;
    tick();
    memwrite = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    memread = 1'b1;
    adr     = 8'h02;
    #1;
    n_tests++;
    if ({load_ready, cpu_reset, running, out_valid} !== 4'b1100) begin
      n_fail++;
      $display("FAIL reset_ctrl: ready/cpurst/run/oval=%b required 1100",
               {load_ready, cpu_reset, running, out_valid});
    end
    n_tests++;
    if (out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_out_data: got %h required 00", out_data);
    end
    n_tests++;
    if (memdata !== 8'h00) begin
      n_fail++;
      $display("FAIL load_memdata: got %h required 00", memdata);
    end
    memread = 1'b0;
  endtask

  task automatic test_load4();
    logic [7:0] d;
    load_byte(8'h20, 1'b0);
    load_byte(8'h02, 1'b0);
    load_byte(8'h00, 1'b0);
    load_byte(8'h05, 1'b1);
    n_tests++;
    if ({running, cpu_reset, load_ready} !== 3'b100) begin
      n_fail++;
      $display("FAIL load4_run: run/cpurst/ready=%b required 100", {running, cpu_reset, load_ready});
    end
    core_read(8'h02, d);
    n_tests++;
    if (d !== 8'h00) begin n_fail++; $display("FAIL load4_rd2: got %h required 00", d); end
    core_read(8'h03, d);
    n_tests++;
    if (d !== 8'h05) begin n_fail++; $display("FAIL load4_rd3: got %h required 05", d); end
    core_read(8'h00, d);
    n_tests++;
    if (d !== 8'h20) begin n_fail++; $display("FAIL load4_rd0: got %h required 20", d); end
  endtask

  task automatic test_write_read();
    logic [7:0] d;
    core_write(8'h10, 8'hA5);
    core_read(8'h10, d);
    n_tests++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL wr_rd: got %h required a5", d); end
    core_read(8'h50, d);
    n_tests++;
    if (d !== 8'hA5) begin n_fail++; $display("FAIL wr_alias: got %h required a5", d); end
    adr = 8'h10;
    #1;
    n_tests++;
    if (memdata !== 8'h00) begin n_fail++; $display("FAIL noread_zero: got %h required 00", memdata); end
    // Simultaneous read and write: old data visible now, new data next cycle
    memread   = 1'b1;
    memwrite  = 1'b1;
    adr       = 8'h10;
    writedata = 8'h5A;
    #1;
    n_tests++;
    if (memdata !== 8'hA5) begin n_fail++; $display("FAIL rw_same_old: got %h required a5", memdata); end
    tick();
    memwrite = 1'b0;
    #1;
    n_tests++;
    if (memdata !== 8'h5A) begin n_fail++; $display("FAIL rw_same_new: got %h required 5a", memdata); end
    memread = 1'b0;
  endtask

  task automatic test_out_port();
    logic [7:0] d;
    core_write(8'h3F, 8'h77);
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL oval_ram_store: got %b required 0", out_valid); end
    core_write(8'hFF, 8'h3C);
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h3C) begin
      n_fail++;
      $display("FAIL out_store: valid=%b data=%h required 1/3c", out_valid, out_data);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL out_pulse_len: got %b required 0", out_valid); end
    core_read(8'h3F, d);
    n_tests++;
    if (d !== 8'h77) begin n_fail++; $display("FAIL out_ram63: got %h required 77", d); end
    core_read(8'hFF, d);
    n_tests++;
    if (d !== 8'h3C) begin n_fail++; $display("FAIL out_readback: got %h required 3c", d); end
  endtask

  task automatic test_back_to_back();
    memwrite  = 1'b1;
    adr       = 8'hFF;
    writedata = 8'h11;
    tick();
    writedata = 8'h22;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      n_fail++;
      $display("FAIL b2b_first: valid=%b data=%h required 1/11", out_valid, out_data);
    end
    tick();
    memwrite = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 8'h22) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b data=%h required 1/22", out_valid, out_data);
    end
    tick();
    n_tests++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_end: got %b required 0", out_valid); end
  endtask

  task automatic test_full64();
    logic [7:0] d;
    do_reset();
    for (int i = 0; i < 64; i++) begin
      load_byte(8'(i * 3 + 1), 1'b0);
      if (i == 62) begin
        n_tests++;
        if (running !== 1'b0) begin n_fail++; $display("FAIL full64_early: got %b required 0", running); end
      end
    end
    n_tests++;
    if (running !== 1'b1 || load_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL full64_run: run/ready=%b%b required 10", running, load_ready);
    end
    // Loader is ignored once running
    load_valid = 1'b1;
    load_data  = 8'hEE;
    tick();
    load_valid = 1'b0;
    core_read(8'h3F, d);
    n_tests++;
    if (d !== 8'hBE) begin n_fail++; $display("FAIL full64_ram63: got %h required be", d); end
    core_read(8'h00, d);
    n_tests++;
    if (d !== 8'h01) begin n_fail++; $display("FAIL full64_ram0: got %h required 01", d); end
    core_read(8'h20, d);
    n_tests++;
    if (d !== 8'h61) begin n_fail++; $display("FAIL full64_ram32: got %h required 61", d); end
  endtask

  task automatic test_midrun_reset();
    logic [7:0] d;
    core_write(8'hFF, 8'h44);
    core_write(8'h01, 8'h02);
    do_reset();
    n_tests++;
    if (running !== 1'b0 || cpu_reset !== 1'b1 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL midrun_reset: run=%b cpurst=%b out=%h required 0/1/00", running, cpu_reset, out_data);
    end
    core_write(8'h01, 8'hEE);
    core_write(8'hFF, 8'h99);
    n_tests++;
    if (out_valid !== 1'b0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL load_outstore_drop: valid=%b data=%h required 0/00", out_valid, out_data);
    end
    load_byte(8'h99, 1'b1);
    n_tests++;
    if (running !== 1'b1) begin n_fail++; $display("FAIL one_byte_run: got %b required 1", running); end
    core_read(8'h00, d);
    n_tests++;
    if (d !== 8'h99) begin n_fail++; $display("FAIL one_byte_ram0: got %h required 99", d); end
    core_read(8'h01, d);
    n_tests++;
    if (d !== 8'h02) begin n_fail++; $display("FAIL load_write_drop: got %h required 02", d); end
  endtask

  task automatic test_gaps();
    logic [7:0] d;
    do_reset();
    load_byte(8'hA1, 1'b0);
    load_valid = 1'b0;
    load_data  = 8'hB2;
    tick();
    load_byte(8'hC3, 1'b0);
    load_byte(8'hD4, 1'b0);
    n_tests++;
    if (running !== 1'b0) begin n_fail++; $display("FAIL gaps_still_load: got %b required 0", running); end
    load_byte(8'hE5, 1'b1);
    core_read(8'h00, d);
    n_tests++;
    if (d !== 8'hA1) begin n_fail++; $display("FAIL gaps_ram0: got %h required a1", d); end
    core_read(8'h01, d);
    n_tests++;
    if (d !== 8'hC3) begin n_fail++; $display("FAIL gaps_ram1: got %h required c3", d); end
    core_read(8'h02, d);
    n_tests++;
    if (d !== 8'hD4) begin n_fail++; $display("FAIL gaps_ram2: got %h required d4", d); end
    core_read(8'h03, d);
    n_tests++;
    if (d !== 8'hE5) begin n_fail++; $display("FAIL gaps_ram3: got %h required e5", d); end
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    test_reset();
    test_load4();
    test_write_read();
    test_out_port();
    test_back_to_back();
    test_full64();
    test_midrun_reset();
    test_gaps();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_mips_mem_responder

`default_nettype wire
